// File: rtl/video_pkg.sv
// Video-path constants shared by the PSRAM line fetch logic.
package video_pkg;
    localparam int H_RES           = 800;
    localparam int V_RES           = 480;
    localparam int BURST_LEN       = 16;
    localparam int LINE_BYTES      = H_RES * 4;
    localparam int BURSTS_PER_LINE = H_RES / BURST_LEN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } fetch_state_e;
endpackage

// File: rtl/toggle_sync.sv
// Brings a pixel-domain toggle into clk_psram; one-cycle pulse per flip.
module toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic tog_i,
    output logic ev_o
);
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = tog_i;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign ev_o = s2_q ^ s3_q;
endmodule

// File: rtl/line_fetch_ctrl.sv
// Refills a video line buffer from PSRAM with BURST_LEN-word read bursts.
module line_fetch_ctrl #(
    parameter int H_RES     = video_pkg::H_RES,
    parameter int V_RES     = video_pkg::V_RES,
    parameter int BURST_LEN = video_pkg::BURST_LEN,
    parameter int FB_BASE   = 0,
    parameter int ADDR_W    = 22
) (
    input  logic              clk_psram,
    input  logic              rst,
    input  logic              line_toggle,
    input  logic              frame_toggle,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              rd_valid,
    input  logic [31:0]       rd_data,
    output logic [9:0]        wr_addr,
    output logic [23:0]       wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);
    import video_pkg::*;

    localparam int BPL    = H_RES / BURST_LEN;
    localparam int BI_W   = $clog2(BPL + 1);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int LC_W   = $clog2(V_RES + 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] LINE_A  = ADDR_W'(H_RES * 4);
    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN * 4);

    fetch_state_e      state_q, state_d;
    logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              pending_q, pending_d;
    logic              abort_q, abort_d;
    logic [BI_W-1:0]   burst_idx_q, burst_idx_d;
    logic [9:0]        pix_idx_q, pix_idx_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [9:0]        wr_addr_q, wr_addr_d;
    logic [23:0]       wr_data_q, wr_data_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        ovr_cnt_q, ovr_cnt_d;

    logic line_ev, frame_ev;
    logic go_fresh, consume;
    logic unused_rd_hi;

    toggle_sync u_line_sync (
        .clk   (clk_psram),
        .rst   (rst),
        .tog_i (line_toggle),
        .ev_o  (line_ev)
    );

    toggle_sync u_frame_sync (
        .clk   (clk_psram),
        .rst   (rst),
        .tog_i (frame_toggle),
        .ev_o  (frame_ev)
    );

    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        line_base_d = line_base_q;
        pending_d   = pending_q;
        abort_d     = abort_q;
        burst_idx_d = burst_idx_q;
        pix_idx_d   = pix_idx_q;
        beat_d      = beat_q;
        cmd_addr_d  = cmd_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        overrun_d   = 1'b0;
        ovr_cnt_d   = ovr_cnt_q;
        go_fresh    = 1'b0;
        consume     = 1'b0;

        // A frame restart supersedes any queued line request.
        if (frame_ev) begin
            line_cnt_d  = '0;
            line_base_d = BASE_A;
            pending_d   = 1'b0;
            abort_d     = (state_q == ST_CMD) || (state_q == ST_DATA);
        end

        unique case (state_q)
            ST_IDLE: go_fresh = frame_ev || line_ev || pending_q;
            ST_CMD: begin
                if (cmd_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rd_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rd_data[23:0];
                    wr_addr_d = pix_idx_q;
                    pix_idx_d = pix_idx_q + 10'd1;
                    beat_d    = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        beat_d = '0;
                        if (abort_q || frame_ev) begin
                            go_fresh = 1'b1;
                        end else if (burst_idx_q == BI_W'(BPL - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            burst_idx_d = burst_idx_q + BI_W'(1);
                            cmd_addr_d  = cmd_addr_q + BURST_A;
                            state_d     = ST_CMD;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!frame_ev) begin
                    if (line_cnt_q == LC_W'(V_RES - 1)) begin
                        line_cnt_d  = '0;
                        line_base_d = BASE_A;
                    end else begin
                        line_cnt_d  = line_cnt_q + LC_W'(1);
                        line_base_d = line_base_q + LINE_A;
                    end
                end
                go_fresh = frame_ev || pending_q;
                if (!go_fresh) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_fresh) begin
            state_d     = ST_CMD;
            burst_idx_d = '0;
            pix_idx_d   = '0;
            beat_d      = '0;
            abort_d     = 1'b0;
            cmd_addr_d  = line_base_d;
            consume     = (state_q != ST_DATA);
            if (consume) pending_d = 1'b0;
        end

        if (line_ev && !frame_ev && (state_q != ST_IDLE || pending_q)) begin
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
                ovr_cnt_d = (ovr_cnt_q == 8'hFF) ? ovr_cnt_q : ovr_cnt_q + 8'd1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_psram or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            line_cnt_q  <= '0;
            line_base_q <= BASE_A;
            pending_q   <= 1'b0;
            abort_q     <= 1'b0;
            burst_idx_q <= '0;
            pix_idx_q   <= '0;
            beat_q      <= '0;
            cmd_addr_q  <= BASE_A;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            line_base_q <= line_base_d;
            pending_q   <= pending_d;
            abort_q     <= abort_d;
            burst_idx_q <= burst_idx_d;
            pix_idx_q   <= pix_idx_d;
            beat_q      <= beat_d;
            cmd_addr_q  <= cmd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign unused_rd_hi = ^rd_data[31:24];
    assign cmd_valid    = (state_q == ST_CMD);
    assign cmd_addr     = cmd_addr_q;
    assign busy         = (state_q != ST_IDLE);
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign overrun      = overrun_q;
    assign overrun_cnt  = ovr_cnt_q;
endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed + randomized bench for line_fetch_ctrl with a PSRAM responder.
module tb_line_fetch_ctrl;
    localparam int H   = 800;
    localparam int BL  = 16;
    localparam int NB  = H / BL;
    localparam int AW  = 22;
    localparam int SFB = 'h3FF000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          line_t = 0, frame_t = 0, cmd_ready = 0, rd_valid = 0;
    logic [31:0]   rd_data = 0;
    logic          cmd_valid, wr_en, busy, overrun;
    logic [AW-1:0] cmd_addr;
    logic [9:0]    wr_addr;
    logic [23:0]   wr_data;
    logic [7:0]    overrun_cnt;

    logic          s_line_t = 0, s_frame_t = 0, s_cmd_ready = 0, s_rd_valid = 0;
    logic [31:0]   s_rd_data = 0;
    logic          s_cmd_valid, s_wr_en, s_busy, s_overrun;
    logic [AW-1:0] s_cmd_addr;
    logic [9:0]    s_wr_addr;
    logic [23:0]   s_wr_data;
    logic [7:0]    s_ovr_cnt;

    line_fetch_ctrl u_dut (
        .clk_psram(clk), .rst(rst),
        .line_toggle(line_t), .frame_toggle(frame_t),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    line_fetch_ctrl #(
        .H_RES(16), .V_RES(480), .BURST_LEN(16), .FB_BASE(SFB), .ADDR_W(AW)
    ) u_small (
        .clk_psram(clk), .rst(rst),
        .line_toggle(s_line_t), .frame_toggle(s_frame_t),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_addr(s_cmd_addr),
        .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_en(s_wr_en),
        .busy(s_busy), .overrun(s_overrun), .overrun_cnt(s_ovr_cnt)
    );

    typedef struct {
        logic [9:0]  a;
        logic [23:0] d;
    } wexp_t;

    wexp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int ov_seen = 0;
    int s_wr_cnt = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(int line, int b);
        return AW'(longint'(line) * H * 4 + longint'(b) * BL * 4);
    endfunction

    function automatic logic [AW-1:0] s_exp(int k);
        return AW'(longint'(SFB) + longint'(k) * 64);
    endfunction

    function automatic logic [23:0] s_pat(int k);
        return 24'(k * 37 + 5);
    endfunction

    // Write-port scoreboard: every strobe must match the next expected pixel.
    always @(negedge clk) begin : mon
        wexp_t w;
        if (!rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(w.a));
                    chk("wr_data", 64'(wr_data), 64'(w.d));
                end
            end
            if (overrun) ov_seen++;
            if (s_wr_en) begin
                chk("s_wr_addr", 64'(s_wr_addr), 64'(s_wr_cnt % 16));
                chk("s_wr_data", 64'(s_wr_data), 64'(s_pat(s_wr_cnt)));
                s_wr_cnt++;
            end
            if (s_overrun) chk("s_overrun", 1, 0);
        end
    end

    task automatic wait_cmd(string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_cmd_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(string tag);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_busy_drop"}, 64'(ok), 1);
    endtask

    task automatic serve_burst(int line, int b, int stall, bit fixed,
                               bit junk, bit fflip, int nbeats);
        bit ok;
        logic [AW-1:0] ea;
        logic [31:0] d;
        int st;
        wait_cmd("burst", ok);
        if (!ok) return;
        ea = exp_addr(line, b);
        chk("cmd_addr", 64'(cmd_addr), 64'(ea));
        st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int i = 0; i < st; i++) begin
            rd_valid = junk;
            rd_data = 32'hDEADBEEF;
            @(negedge clk);
            chk("hold_valid", 64'(cmd_valid), 1);
            chk("hold_addr", 64'(cmd_addr), 64'(ea));
            chk("hold_no_wr", 64'(wr_en), 0);
        end
        rd_valid = 0;
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        if (fflip) frame_t = ~frame_t;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rd_valid = 0;
                @(negedge clk);
            end
            d = fixed ? 32'hAA123456 : $urandom;
            rd_valid = 1;
            rd_data = d;
            exp_q.push_back('{a: 10'(b * BL + i), d: d[23:0]});
            @(negedge clk);
        end
        rd_valid = 0;
    endtask

    task automatic serve_line(int line, int stall0, bit fixed, int fa, int fb);
        for (int b = 0; b < NB; b++) begin
            serve_burst(line, b, (b == 0) ? stall0 : -1, fixed && b == 0,
                        stall0 > 0 && b == 0, 0, BL);
            if (b == fa || b == fb) line_t = ~line_t;
        end
    endtask

    initial begin
        #1 rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 64'(cmd_valid), 0);
        chk("rst_cmd_addr", 64'(cmd_addr), 0);
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_wr_addr", 64'(wr_addr), 0);
        chk("rst_wr_data", 64'(wr_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_ovr_cnt", 64'(overrun_cnt), 0);
        chk("rst_s_cmd_addr", 64'(s_cmd_addr), 64'(SFB));
        rst = 0;

        // Stray read data while idle must never reach the line buffer.
        rd_valid = 1;
        rd_data = 32'h11223344;
        repeat (3) @(negedge clk);
        rd_valid = 0;
        chk("idle_no_wr", 64'(wr_en), 0);

        frame_t = ~frame_t;
        serve_line(0, -1, 0, -1, -1);
        wait_idle("line0");

        line_t = ~line_t;
        serve_line(1, 20, 1, -1, -1);
        wait_idle("line1");

        line_t = ~line_t;
        serve_line(2, -1, 0, 5, 10);
        serve_line(3, -1, 0, -1, -1);
        wait_idle("pend");
        chk("ov_pulses", 64'(ov_seen), 1);
        chk("ov_cnt", 64'(overrun_cnt), 1);

        line_t = ~line_t;
        for (int b = 0; b < 10; b++) serve_burst(4, b, -1, 0, 0, 0, BL);
        serve_burst(4, 10, -1, 0, 0, 1, BL);
        serve_line(0, -1, 0, -1, -1);
        wait_idle("abort");

        frame_t = ~frame_t;
        line_t = ~line_t;
        serve_line(0, -1, 0, -1, -1);
        wait_idle("both");
        repeat (8) @(negedge clk);
        chk("both_no_pend", 64'(busy), 0);
        chk("both_ov_cnt", 64'(overrun_cnt), 1);

        line_t = ~line_t;
        serve_burst(1, 0, 0, 0, 0, 0, 5);
        chk("pre_rst_wr_en", 64'(wr_en), 1);
        #1 rst = 1;
        #1;
        chk("arst_wr_en", 64'(wr_en), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_cmd_valid", 64'(cmd_valid), 0);
        chk("arst_cmd_addr", 64'(cmd_addr), 0);
        chk("arst_wr_addr", 64'(wr_addr), 0);
        chk("arst_wr_data", 64'(wr_data), 0);
        chk("arst_ovr_cnt", 64'(overrun_cnt), 0);
        exp_q.delete();
        line_t = 0;
        frame_t = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 64'(busy), 0);

        // Small-line instance: walk a whole frame and one line past the wrap.
        s_frame_t = ~s_frame_t;
        for (int n = 0; n <= 480; n++) begin
            bit ok = 0;
            if (n > 0) s_line_t = ~s_line_t;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (s_cmd_valid) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) begin
                chk("s_cmd_timeout", 0, 1);
                break;
            end
            chk((n == 480) ? "s_wrap_addr" : "s_cmd_addr",
                64'(s_cmd_addr), 64'(s_exp(n % 480)));
            s_cmd_ready = 1;
            @(negedge clk);
            s_cmd_ready = 0;
            s_rd_valid = 1;
            for (int i = 0; i < 16; i++) begin
                s_rd_data = 32'hEE000000 | 32'(s_pat(n * 16 + i));
                @(negedge clk);
            end
            s_rd_valid = 0;
            ok = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!s_busy) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) chk("s_busy_drop", 0, 1);
        end
        chk("s_wr_count", 64'(s_wr_cnt), 481 * 16);
        chk("s_ovr_cnt", 64'(s_ovr_cnt), 0);
        chk("exp_q_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
